// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath defaults, ALU op codes and the
// control-bit bundle that travels down the pipeline with each instruction.
package cpu_pkg;

    localparam int DWIDTH_DEF = 32;
    localparam int RIDX_DEF   = 5;

    // ALU op codes as presented to the execute-stage ALU
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRL = 4'b1010;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SRA = 4'b1101;
    localparam logic [3:0] ALU_LUI = 4'b1110;

    // Control bits that follow an instruction into EX
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ctrl_t;

    // A bubble carries no side effects
    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/fwd_mux.sv
// Single-operand forwarding selector. EX/MEM wins over MEM/WB; register 0
// is never forwarded because it is hard-wired to zero.
module fwd_mux
    import cpu_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int RIDX   = RIDX_DEF
) (
    input  logic [RIDX-1:0]   src_idx,
    input  logic [DWIDTH-1:0] reg_val,
    input  logic              exmem_reg_write,
    input  logic [RIDX-1:0]   exmem_rd_idx,
    input  logic [DWIDTH-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [RIDX-1:0]   memwb_rd_idx,
    input  logic [DWIDTH-1:0] memwb_result,
    output logic [DWIDTH-1:0] fwd_val
);

    // Pick the youngest in-flight producer of src_idx, else the latched value
    always_comb begin
        fwd_val = reg_val;
        if (src_idx != '0) begin
            if (exmem_reg_write && (exmem_rd_idx == src_idx)) begin
                fwd_val = exmem_result;
            end else if (memwb_reg_write && (memwb_rd_idx == src_idx)) begin
                fwd_val = memwb_result;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// Update priority each edge: rst > flush > stall > load-use bubble > load.
// While stalled, the latched rs/rt data are refreshed with their forwarded
// values so a producer that retires during the hold is not lost.
// Optional macro IDEX_PERF_CNT_EN adds stall_cnt / bubble_cnt counters.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int RIDX   = RIDX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [3:0]        id_alu_op,
    input  logic [DWIDTH-1:0] id_rs_data,
    input  logic [DWIDTH-1:0] id_rt_data,
    input  logic [DWIDTH-1:0] id_imm,
    input  logic [RIDX-1:0]   id_rs_idx,
    input  logic [RIDX-1:0]   id_rt_idx,
    input  logic [RIDX-1:0]   id_rd_idx,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_src_a_sel,
    input  logic              id_src_b_sel,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              stall,
    input  logic              flush,
    input  logic              exmem_reg_write,
    input  logic [RIDX-1:0]   exmem_rd_idx,
    input  logic [DWIDTH-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [RIDX-1:0]   memwb_rd_idx,
    input  logic [DWIDTH-1:0] memwb_result,
    output logic              ex_valid,
    output logic [3:0]        alu_op,
    output logic [DWIDTH-1:0] alu_rs1,
    output logic [DWIDTH-1:0] alu_rs2,
    output logic [DWIDTH-1:0] ex_store_data,
    output logic [RIDX-1:0]   ex_rd_idx,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ld_use_stall
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    logic              valid_q,     valid_d;
    logic [3:0]        alu_op_q,    alu_op_d;
    logic [DWIDTH-1:0] rs_data_q,   rs_data_d;
    logic [DWIDTH-1:0] rt_data_q,   rt_data_d;
    logic [DWIDTH-1:0] imm_q,       imm_d;
    logic [RIDX-1:0]   rs_idx_q,    rs_idx_d;
    logic [RIDX-1:0]   rt_idx_q,    rt_idx_d;
    logic [RIDX-1:0]   rd_idx_q,    rd_idx_d;
    logic              src_a_sel_q, src_a_sel_d;
    logic              src_b_sel_q, src_b_sel_d;
    ctrl_t             ctrl_q,      ctrl_d;

    logic [DWIDTH-1:0] rs_fwd;
    logic [DWIDTH-1:0] rt_fwd;
    logic              ld_use;
    logic              load_bubble;

    fwd_mux #(.DWIDTH(DWIDTH), .RIDX(RIDX)) u_fwd_rs (
        .src_idx         (rs_idx_q),
        .reg_val         (rs_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd_idx    (exmem_rd_idx),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd_idx    (memwb_rd_idx),
        .memwb_result    (memwb_result),
        .fwd_val         (rs_fwd)
    );

    fwd_mux #(.DWIDTH(DWIDTH), .RIDX(RIDX)) u_fwd_rt (
        .src_idx         (rt_idx_q),
        .reg_val         (rt_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd_idx    (exmem_rd_idx),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd_idx    (memwb_rd_idx),
        .memwb_result    (memwb_result),
        .fwd_val         (rt_fwd)
    );

    // Load-use hazard: a load in EX whose destination the ID instruction reads
    always_comb begin
        ld_use = 1'b0;
        if (valid_q && ctrl_q.mem_read && (rd_idx_q != '0) && id_valid) begin
            ld_use = (id_use_rs && (id_rs_idx == rd_idx_q)) ||
                     (id_use_rt && (id_rt_idx == rd_idx_q));
        end
    end

    // A bubble enters on flush, on a load-use hold, or when ID is empty
    assign load_bubble = flush || (!stall && (ld_use || !id_valid));

    // Next-state selection for the stage register
    always_comb begin
        valid_d     = valid_q;
        alu_op_d    = alu_op_q;
        rs_data_d   = rs_fwd;
        rt_data_d   = rt_fwd;
        imm_d       = imm_q;
        rs_idx_d    = rs_idx_q;
        rt_idx_d    = rt_idx_q;
        rd_idx_d    = rd_idx_q;
        src_a_sel_d = src_a_sel_q;
        src_b_sel_d = src_b_sel_q;
        ctrl_d      = ctrl_q;
        if (load_bubble) begin
            valid_d     = 1'b0;
            alu_op_d    = '0;
            rs_data_d   = '0;
            rt_data_d   = '0;
            imm_d       = '0;
            rs_idx_d    = '0;
            rt_idx_d    = '0;
            rd_idx_d    = '0;
            src_a_sel_d = 1'b0;
            src_b_sel_d = 1'b0;
            ctrl_d      = CTRL_NONE;
        end else if (!stall) begin
            valid_d     = 1'b1;
            alu_op_d    = id_alu_op;
            rs_data_d   = id_rs_data;
            rt_data_d   = id_rt_data;
            imm_d       = id_imm;
            rs_idx_d    = id_rs_idx;
            rt_idx_d    = id_rt_idx;
            rd_idx_d    = id_rd_idx;
            src_a_sel_d = id_src_a_sel;
            src_b_sel_d = id_src_b_sel;
            ctrl_d      = '{reg_write:  id_reg_write,
                            mem_read:   id_mem_read,
                            mem_write:  id_mem_write,
                            mem_to_reg: id_mem_to_reg};
        end
    end

    // Stage register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            alu_op_q    <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            rs_idx_q    <= '0;
            rt_idx_q    <= '0;
            rd_idx_q    <= '0;
            src_a_sel_q <= 1'b0;
            src_b_sel_q <= 1'b0;
            ctrl_q      <= CTRL_NONE;
        end else begin
            valid_q     <= valid_d;
            alu_op_q    <= alu_op_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            rs_idx_q    <= rs_idx_d;
            rt_idx_q    <= rt_idx_d;
            rd_idx_q    <= rd_idx_d;
            src_a_sel_q <= src_a_sel_d;
            src_b_sel_q <= src_b_sel_d;
            ctrl_q      <= ctrl_d;
        end
    end

    // Operand muxing toward the ALU; shifts take the value from rt
    always_comb begin
        alu_rs1       = src_a_sel_q ? rt_fwd : rs_fwd;
        alu_rs2       = src_b_sel_q ? imm_q  : rt_fwd;
        ex_store_data = rt_fwd;
    end

    assign ex_valid      = valid_q;
    assign alu_op        = alu_op_q;
    assign ex_rd_idx     = rd_idx_q;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ld_use_stall  = ld_use;

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] stall_cnt_q,  stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Counters wrap naturally at 2^32
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (stall && !flush) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (load_bubble) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a behavioural model of the EX-resident
// instruction is checked on every falling edge, and literal expectations
// pin the key scenarios (reset, forward priority, r0, load-use, stall
// refresh, flush during stall, shift operand routing).
module tb_id_ex_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [3:0]  id_alu_op;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs_idx, id_rt_idx, id_rd_idx;
  logic        id_use_rs, id_use_rt, id_src_a_sel, id_src_b_sel;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        stall, flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd_idx, memwb_rd_idx;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_valid;
  logic [3:0]  alu_op;
  logic [31:0] alu_rs1, alu_rs2, ex_store_data;
  logic [4:0]  ex_rd_idx;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic        ld_use_stall;
`ifdef IDEX_PERF_CNT_EN
  logic [31:0] stall_cnt, bubble_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_alu_op(id_alu_op),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs_idx(id_rs_idx), .id_rt_idx(id_rt_idx), .id_rd_idx(id_rd_idx),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_src_a_sel(id_src_a_sel), .id_src_b_sel(id_src_b_sel),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .stall(stall), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd_idx(exmem_rd_idx),
    .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd_idx(memwb_rd_idx),
    .memwb_result(memwb_result),
    .ex_valid(ex_valid), .alu_op(alu_op), .alu_rs1(alu_rs1),
    .alu_rs2(alu_rs2), .ex_store_data(ex_store_data), .ex_rd_idx(ex_rd_idx),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ld_use_stall(ld_use_stall)
`ifdef IDEX_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp_v, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        valid;
    logic [3:0]  op;
    logic [31:0] rs, rt, imm;
    logic [4:0]  rsi, rti, rdi;
    logic        sa, sb, rw, mr, mw, m2r;
  } stage_t;

  stage_t m;
  bit     started = 0;

  // What value register idx really holds right now, given in-flight producers
  function automatic logic [31:0] live_value(input logic [4:0] idx, input logic [31:0] v);
    if (idx == 5'd0) return v;
    if (exmem_reg_write && exmem_rd_idx == idx) return exmem_result;
    if (memwb_reg_write && memwb_rd_idx == idx) return memwb_result;
    return v;
  endfunction

  function automatic logic model_ld_use();
    if (!(m.valid && m.mr && m.rdi != 5'd0 && id_valid)) return 1'b0;
    return (id_use_rs && id_rs_idx == m.rdi) || (id_use_rt && id_rt_idx == m.rdi);
  endfunction

  // Model advance on each rising edge
  always @(posedge clk) begin
    logic [31:0] new_rs, new_rt;
    if (rst) begin
      m = '{default: 0};
      started = 1;
    end else if (flush || (!stall && (model_ld_use() || !id_valid))) begin
      m = '{default: 0};
    end else if (stall) begin
      new_rs = live_value(m.rsi, m.rs);
      new_rt = live_value(m.rti, m.rt);
      m.rs = new_rs;
      m.rt = new_rt;
    end else begin
      m.valid = 1'b1;       m.op  = id_alu_op;
      m.rs  = id_rs_data;   m.rt  = id_rt_data;  m.imm = id_imm;
      m.rsi = id_rs_idx;    m.rti = id_rt_idx;   m.rdi = id_rd_idx;
      m.sa  = id_src_a_sel; m.sb  = id_src_b_sel;
      m.rw  = id_reg_write; m.mr  = id_mem_read;
      m.mw  = id_mem_write; m.m2r = id_mem_to_reg;
    end
  end

  // Compare process on every falling edge
  always @(negedge clk) begin
    if (started) begin
      check("mdl_ex_valid", {31'd0, ex_valid}, {31'd0, m.valid});
      check("mdl_ctrl", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
            {28'd0, m.rw, m.mr, m.mw, m.m2r});
      check("mdl_ld_use", {31'd0, ld_use_stall}, {31'd0, model_ld_use()});
      if (m.valid) begin
        check("mdl_alu_op", {28'd0, alu_op}, {28'd0, m.op});
        check("mdl_rd_idx", {27'd0, ex_rd_idx}, {27'd0, m.rdi});
        check("mdl_alu_rs1", alu_rs1, m.sa ? live_value(m.rti, m.rt) : live_value(m.rsi, m.rs));
        check("mdl_alu_rs2", alu_rs2, m.sb ? m.imm : live_value(m.rti, m.rt));
        check("mdl_store", ex_store_data, live_value(m.rti, m.rt));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] ed, input logic [31:0] er,
                         input logic mw, input logic [4:0] md, input logic [31:0] mr);
    exmem_reg_write = ew; exmem_rd_idx = ed; exmem_result = er;
    memwb_reg_write = mw; memwb_rd_idx = md; memwb_result = mr;
  endtask

  // ctrl = {reg_write, mem_read, mem_write, mem_to_reg}
  task automatic issue(input logic [3:0] op, input logic [4:0] rsi, input logic [4:0] rti,
                       input logic [4:0] rdi, input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic [31:0] imm, input logic [3:0] ctrl,
                       input logic sa, input logic sb, input logic urs, input logic urt);
    id_valid = 1'b1; id_alu_op = op;
    id_rs_idx = rsi; id_rt_idx = rti; id_rd_idx = rdi;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg} = ctrl;
    id_src_a_sel = sa; id_src_b_sel = sb; id_use_rs = urs; id_use_rt = urt;
  endtask

  task automatic idle_id();
    issue(4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    id_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_fwd(0, 0, 0, 0, 0, 0);
    // ADD r4 = r1 + r2, presented throughout reset
    issue(ALU_ADD, 5'd1, 5'd2, 5'd4, 32'h100, 32'h23, 32'd0, 4'b1000, 0, 0, 1, 1);
    tick(); tick();
    check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_alu_op", {28'd0, alu_op}, 32'd0);
    check("rst_ctrl", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 32'd0);
    check("rst_alu_rs1", alu_rs1, 32'd0);
    check("rst_ld_use", {31'd0, ld_use_stall}, 32'd0);
    rst = 1'b0;
    tick();
    check("first_valid", {31'd0, ex_valid}, 32'd1);
    check("first_op", {28'd0, alu_op}, {28'd0, ALU_ADD});
    check("first_rs1", alu_rs1, 32'h100);
    check("first_rs2", alu_rs2, 32'h23);
    check("first_rd", {27'd0, ex_rd_idx}, 32'd4);

    // Forward priority: SUB rs=r3 rt=r0; EX/MEM r3=0x11, MEM/WB r3=0x22
    issue(ALU_SUB, 5'd3, 5'd0, 5'd6, 32'h99, 32'd0, 32'd0, 4'b1000, 0, 0, 1, 1);
    tick();
    idle_id();
    set_fwd(1, 5'd3, 32'h11, 1, 5'd3, 32'h22);
    #1;
    check("prio_rs1", alu_rs1, 32'h11);
    check("prio_rs2", alu_rs2, 32'd0);
    check("prio_op", {28'd0, alu_op}, {28'd0, ALU_SUB});
    set_fwd(0, 5'd3, 32'h11, 1, 5'd3, 32'h22);
    #1;
    check("memwb_rs1", alu_rs1, 32'h22);

    // r0 guard
    issue(ALU_OR, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 32'd0, 4'b1000, 0, 0, 1, 1);
    tick();
    idle_id();
    set_fwd(1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF);
    #1;
    check("r0_rs1", alu_rs1, 32'd0);
    check("r0_rs2", alu_rs2, 32'd0);

    // Load-use: lw r5, 4(r1) then ADD r6 = r5 + r1
    set_fwd(0, 0, 0, 0, 0, 0);
    issue(ALU_ADD, 5'd1, 5'd5, 5'd5, 32'h1000, 32'd0, 32'd4, 4'b1101, 0, 1, 1, 0);
    tick();
    issue(ALU_ADD, 5'd5, 5'd1, 5'd6, 32'h5, 32'h7, 32'd0, 4'b1000, 0, 0, 1, 1);
    #1;
    check("lu_stall", {31'd0, ld_use_stall}, 32'd1);
    tick();
    set_fwd(1, 5'd5, 32'h1004, 0, 0, 0);
    #1;
    check("lu_bubble", {31'd0, ex_valid}, 32'd0);
    check("lu_released", {31'd0, ld_use_stall}, 32'd0);
    tick();
    idle_id();
    set_fwd(0, 0, 0, 1, 5'd5, 32'hABCD);
    #1;
    check("lu_valid", {31'd0, ex_valid}, 32'd1);
    check("lu_rs1", alu_rs1, 32'hABCD);
    check("lu_rs2", alu_rs2, 32'h7);

    // Stall refresh: AND rs=r1 rt=r7 while r7 retires with 0x77
    set_fwd(0, 0, 0, 0, 0, 0);
    issue(ALU_AND, 5'd1, 5'd7, 5'd8, 32'h3, 32'h1, 32'd0, 4'b1000, 0, 0, 1, 1);
    tick();
    idle_id();
    stall = 1'b1;
    set_fwd(0, 0, 0, 1, 5'd7, 32'h77);
    #1;
    check("hold_live", alu_rs2, 32'h77);
    tick();
    set_fwd(0, 0, 0, 1, 5'd9, 32'h99);
    tick(); tick();
    stall = 1'b0;
    set_fwd(0, 0, 0, 0, 0, 0);
    #1;
    check("hold_rs2", alu_rs2, 32'h77);
    check("hold_rs1", alu_rs1, 32'h3);
    check("hold_op", {28'd0, alu_op}, {28'd0, ALU_AND});

    // Flush during stall: sw r3, 8(r2)
    issue(ALU_ADD, 5'd2, 5'd3, 5'd0, 32'h40, 32'h55, 32'd8, 4'b0010, 0, 1, 1, 1);
    tick();
    idle_id();
    #1;
    check("sw_memwrite", {31'd0, ex_mem_write}, 32'd1);
    check("sw_rs2", alu_rs2, 32'h8);
    check("sw_store", ex_store_data, 32'h55);
    stall = 1'b1; flush = 1'b1;
    tick();
    stall = 1'b0; flush = 1'b0;
    #1;
    check("flush_valid", {31'd0, ex_valid}, 32'd0);
    check("flush_memwrite", {31'd0, ex_mem_write}, 32'd0);

    // Shift: SLL r10 = r9 << 4, rt routed to alu_rs1
    issue(ALU_SLL, 5'd0, 5'd9, 5'd10, 32'd0, 32'h3, 32'd4, 4'b1000, 1, 1, 0, 1);
    tick();
    idle_id();
    #1;
    check("sll_rs1", alu_rs1, 32'h3);
    check("sll_rs2", alu_rs2, 32'h4);
    set_fwd(1, 5'd9, 32'h5, 0, 0, 0);
    #1;
    check("sll_fwd_rs1", alu_rs1, 32'h5);
    check("sll_fwd_store", ex_store_data, 32'h5);

    // Back-to-back table with mixed forwarding; model checks each cycle
    for (int i = 0; i < 6; i++) begin
      issue((i % 2 == 0) ? ALU_ADD : ALU_NOR, 5'(i + 1), 5'(i + 2), 5'(i + 11),
            32'h1000 + 32'(i), 32'h2000 + 32'(i), 32'(i * 3), 4'b1000,
            1'b0, 1'(i % 3 == 0), 1'b1, 1'b1);
      set_fwd(1'(i % 2), 5'(i + 1), 32'hE000 + 32'(i), 1'b1, 5'(i + 2), 32'hF000 + 32'(i));
      tick();
    end
    idle_id();
    set_fwd(0, 0, 0, 0, 0, 0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage. It sits directly upstream of the execute-stage ALU and feeds its op, rs1 and rs2 inputs.
- Latches decoded instruction fields and control bits from ID, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and detects load-use hazards.
- Supports pipeline hold (stall) and kill (flush, bubble insertion).

Parameters:
- DWIDTH, 32, datapath width.
- RIDX, 5, register index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decode holds a real instruction
- id_alu_op  in  4  ALU op code (AND 0000, OR 0001, ADD 0010, SUB 0110, NOR 1100, SLT 0111, SLL 1001, SRL 1010, SRA 1101, LUI 1110)
- id_rs_data, id_rt_data  in  DWIDTH  register file read data
- id_imm  in  DWIDTH  sign/zero-extended immediate, or shamt in [4:0]
- id_rs_idx, id_rt_idx, id_rd_idx  in  RIDX  source/destination indices
- id_use_rs, id_use_rt  in  1  instruction reads rs / rt
- id_src_a_sel  in  1  0: rs drives alu_rs1; 1: rt drives alu_rs1 (shifts)
- id_src_b_sel  in  1  0: rt drives alu_rs2; 1: imm drives alu_rs2
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  control bits
- stall  in  1  hold stage contents (downstream wait)
- flush  in  1  kill stage contents (branch/jump redirect)
- exmem_reg_write  in  1;  exmem_rd_idx  in  RIDX;  exmem_result  in  DWIDTH
- memwb_reg_write  in  1;  memwb_rd_idx  in  RIDX;  memwb_result  in  DWIDTH
- ex_valid  out  1  stage holds a real instruction
- alu_op  out  4;  alu_rs1, alu_rs2  out  DWIDTH  ALU operands (forwarded, muxed)
- ex_store_data  out  DWIDTH  forwarded rt value for stores
- ex_rd_idx  out  RIDX;  ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1
- ld_use_stall  out  1  ID/IF must hold this cycle

Behaviour:
- Reset: all registered fields, including ex_valid, clear to 0.
  - alu_op resets to 0000; alu_rs1/alu_rs2/ex_store_data read 0.
  - ld_use_stall reads 0.
- Register update priority per rising edge: rst > flush > stall > ld_use_stall > load.
  - flush: ex_valid=0 and all control bits=0. Data fields are don't-care but are cleared. Flush overrides stall.
  - stall (no flush): hold all fields. Additionally, rs_data and rt_data are re-latched with their currently forwarded values, so producers retiring during the hold are not lost.
  - ld_use_stall (no stall/flush): load a bubble (as flush). ID holds the instruction and re-presents it next cycle.
  - else: load all id_* fields, with ex_valid=id_valid. id_valid=0 loads a bubble.
- Forwarding (combinational on registered fields, separately for rs and rt):
  - Source idx==0: no forwarding, register value used.
  - Else if exmem_reg_write and exmem_rd_idx==idx: use exmem_result.
  - Else if memwb_reg_write and memwb_rd_idx==idx: use memwb_result.
  - Else: use the registered value.
  - EX/MEM wins when both match.
- Operand mux:
  - alu_rs1 = src_a_sel ? fwd_rt : fwd_rs.
  - alu_rs2 = src_b_sel ? imm : fwd_rt.
  - ex_store_data = fwd_rt.
- ld_use_stall (combinational) = ex_valid & ex_mem_read & ex_rd_idx!=0 & id_valid & ((id_use_rs & id_rs_idx==ex_rd_idx) | (id_use_rt & id_rt_idx==ex_rd_idx)).
- Latency: 1 cycle from ID to the ALU inputs. Forwarding paths add no cycles.
- Bubbles never assert reg_write or mem_write, so they cause no forwarding or side effects.

Optional Feature:
- Macro IDEX_PERF_CNT_EN.
- Defined: two extra outputs, stall_cnt and bubble_cnt (32 bits each), cleared by rst.
  - stall_cnt increments on every cycle with stall=1 and flush=0.
  - bubble_cnt increments on every edge that loads a bubble (flush, ld_use_stall, or id_valid=0).
  - Both wrap at 2^32-1 → 0.
- Undefined: the ports and logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg holds:
  - ALU op code constants matching the list above.
  - RIDX and DWIDTH defaults.
  - A typedef for the control-bit bundle (reg_write, mem_read, mem_write, mem_to_reg).
- One sub-module, fwd_mux: a single-operand forwarding selector, instantiated twice (rs, rt).

Test Plan:
- Reset: hold rst 2 cycles with id_valid=1 → ex_valid=0, alu_op=0000, all control outputs 0; first edge after release loads the ID fields.
- Forward priority: EX has ADD writing r3=0x11, MEM/WB writing r3=0x22, instruction SUB rs=r3 rt=r0 → alu_rs1=0x11, alu_rs2=0.
- r0 guard: exmem writes r0=0xDEAD and the instruction reads r0 → operand stays 0.
- Load-use: ex stage is lw r5 and ID is ADD r5,r1 → ld_use_stall=1 for 1 cycle and a bubble enters; next cycle the ADD loads and takes r5 from memwb_result.
- Stall refresh: hold 3 cycles while r7 retires from MEM/WB with value 0x77 → after release alu_rs2=0x77 even though MEM/WB no longer carries r7.
- Flush during stall: stall=1, flush=1 → ex_valid=0 and ex_mem_write=0 next cycle.
